vvc_mcm_pipe: RTL and testbench

- Pipelined, parametrised multiple-constant-multiplier bank for the intra angular accelerator.
- Stage 1 builds the shared odd fundamentals of one reference sample X (1x, 3x, ..., (2^C_W-1)x) with shift-add logic only.
- Stage 2 gives each of N_LANE lanes its own run-time coefficient, with a sign, and forms the lane product.
- Stage 3 can feed the lane products into a transposed-form FIR chain. The chain outputs rounded, clipped interpolated samples for fractional-position filtering.

---
 rtl/vvc_mcm_pipe_pkg.sv | 42 ++++
 rtl/vvc_mcm_pipe_if.sv | 36 +++
 rtl/vvc_mcm_pipe_lane.sv | 35 +++
 rtl/vvc_mcm_pipe.sv | 175 +++++++++++++++++
 tb/tb_vvc_mcm_pipe.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vvc_mcm_pipe_pkg.sv
// vvc_mcm_pkg: shared constants, width rule, coefficient split helper.
// No ports; imported by the multiplier bank and its lanes.
package vvc_mcm_pkg;

  localparam int FILT_SHIFT_DEF = 6;
  localparam int OUT_W_DEF = 16;

  function automatic int round_off(input int shift);
    return 1 << (shift - 1);
  endfunction

  localparam int ROUND_OFF = round_off(FILT_SHIFT_DEF);

  typedef logic signed [OUT_W_DEF-1:0] lane_prod_t;

  typedef struct packed {
    logic [15:0] idx;
    logic [3:0]  tz;
  } coef_split_t;

  function automatic bit width_ok(
    input int in_w,
    input int c_w,
    input int out_w
  );
    return out_w >= in_w + c_w + 1;
  endfunction

  // coef = (2*idx+1) << tz; a zero coefficient yields idx=0, tz=0
  function automatic coef_split_t coef_split(
    input logic [15:0] c
  );
    coef_split_t s;
    s = '0;
    for (int i = 15; i >= 0; i--) begin
      if (c[i]) s.tz = 4'(i);
    end
    s.idx = (c >> s.tz) >> 1;
    return s;
  endfunction

endpackage

// File: rtl/vvc_mcm_pipe_if.sv
// vvc_mcm_pipe_if: input beat (valid/ready) and output beat (valid/ready).
// master drives in_* and out_ready; slave is the multiplier bank.
interface vvc_mcm_pipe_if #(
  parameter int IN_W   = 8,
  parameter int C_W    = 6,
  parameter int N_LANE = 4,
  parameter int OUT_W  = 16,
  parameter int ACC_W  = OUT_W + $clog2(N_LANE)
);
  logic                    in_valid;
  logic                    in_ready;
  logic [IN_W-1:0]         in_x;
  logic [N_LANE*C_W-1:0]   in_coef;
  logic [N_LANE-1:0]       in_neg;
  logic                    in_filt;
  logic                    in_clear;
  logic                    out_valid;
  logic                    out_ready;
  logic [N_LANE*OUT_W-1:0] out_prod;
  logic [ACC_W-1:0]        out_acc;
  logic [IN_W-1:0]         out_filt;

  modport master (
    output in_valid, in_x, in_coef, in_neg,
    output in_filt, in_clear, out_ready,
    input  in_ready, out_valid, out_prod,
    input  out_acc, out_filt
  );

  modport slave (
    input  in_valid, in_x, in_coef, in_neg,
    input  in_filt, in_clear, out_ready,
    output in_ready, out_valid, out_prod,
    output out_acc, out_filt
  );
endinterface

// File: rtl/vvc_mcm_pipe_lane.sv
// vvc_mcm_lane: picks the odd fundamental, shifts by tz, applies sign.
// Ports: i_fund (shared odd multiples), i_coef, i_neg -> o_prod.
module vvc_mcm_lane
  import vvc_mcm_pkg::*;
#(
  parameter int C_W   = 6,
  parameter int F_W   = 14,
  parameter int OUT_W = 16
) (
  input  logic [F_W-1:0]          i_fund [2**(C_W-1)],
  input  logic [C_W-1:0]          i_coef,
  input  logic                    i_neg,
  output logic signed [OUT_W-1:0] o_prod
);
  localparam int IDX_W = (C_W > 1) ? C_W - 1 : 1;

  coef_split_t      w_sp;
  logic [IDX_W-1:0] w_idx;
  logic [OUT_W-1:0] w_mag;
  logic             w_unused;

  assign w_unused = ^w_sp.idx[15:IDX_W];

  always_comb begin
    w_sp  = coef_split(16'(i_coef));
    w_idx = w_sp.idx[IDX_W-1:0];
    w_mag = OUT_W'(i_fund[w_idx]) << w_sp.tz;
    if (i_coef == '0)
      o_prod = '0;
    else if (i_neg)
      o_prod = -signed'(w_mag);
    else
      o_prod = signed'(w_mag);
  end
endmodule

// File: rtl/vvc_mcm_pipe.sv
// vvc_mcm_pipe: 3-stage MCM bank (fundamentals, lane products, FIR chain).
// Ports: clk, rst_n, bus (slave side of vvc_mcm_pipe_if).
module vvc_mcm_pipe
  import vvc_mcm_pkg::*;
#(
  parameter int IN_W       = 8,
  parameter int C_W        = 6,
  parameter int N_LANE     = 4,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int ACC_W      = OUT_W + $clog2(N_LANE),
  parameter int FILT_SHIFT = FILT_SHIFT_DEF
) (
  input logic           clk,
  input logic           rst_n,
  vvc_mcm_pipe_if.slave bus
);
  localparam int F_W = IN_W + C_W;
  localparam int NF  = 2**(C_W-1);
  localparam int NT  = N_LANE - 1;
  localparam int RND = round_off(FILT_SHIFT);
  localparam logic signed [ACC_W:0] MAXV =
    (ACC_W+1)'((1 << IN_W) - 1);

  generate
    if (!width_ok(IN_W, C_W, OUT_W)) begin : g_bad_w
      $error("vvc_mcm_pipe: OUT_W too narrow");
    end
  endgenerate

  function automatic logic [F_W-1:0] shadd(
    input logic [IN_W-1:0] x,
    input logic [C_W-1:0]  m
  );
    logic [F_W-1:0] s;
    s = '0;
    for (int b = 0; b < C_W; b++) begin
      if (m[b]) s = s + (F_W'(x) << b);
    end
    return s;
  endfunction

  logic                    w_en;
  logic [F_W-1:0]          w_fund [NF];

  logic                    r_v1;
  logic [F_W-1:0]          r_fund1 [NF];
  logic [N_LANE*C_W-1:0]   r_coef1;
  logic [N_LANE-1:0]       r_neg1;
  logic                    r_filt1;
  logic                    r_clr1;

  logic signed [OUT_W-1:0] w_lane [N_LANE];
  logic                    r_v2;
  logic signed [OUT_W-1:0] r_prod2 [N_LANE];
  logic                    r_filt2;
  logic                    r_clr2;

  logic                    r_v3;
  logic [N_LANE*OUT_W-1:0] r_prod3;
  logic signed [ACC_W-1:0] r_acc3;
  logic [IN_W-1:0]         r_filt3;
  logic signed [ACC_W-1:0] r_tap [NT];

  logic signed [ACC_W-1:0] w_p [N_LANE];
  logic signed [ACC_W-1:0] w_c [NT];
  logic signed [ACC_W-1:0] w_tap_nxt [NT];
  logic signed [ACC_W-1:0] w_acc_nxt;
  logic signed [ACC_W:0]   w_rnd;
  logic signed [ACC_W:0]   w_sh;
  logic [IN_W-1:0]         w_filt_nxt;

  // whole pipe moves as one; bubbles travel with it
  assign w_en         = ~r_v3 | bus.out_ready;
  assign bus.in_ready = w_en;

  generate
    for (genvar j = 0; j < NF; j++) begin : g_fund
      assign w_fund[j] = shadd(bus.in_x, C_W'(2*j+1));
    end
    for (genvar k = 0; k < N_LANE; k++) begin : g_lane
      vvc_mcm_lane #(
        .C_W   (C_W),
        .F_W   (F_W),
        .OUT_W (OUT_W)
      ) u_lane (
        .i_fund (r_fund1),
        .i_coef (r_coef1[k*C_W +: C_W]),
        .i_neg  (r_neg1[k]),
        .o_prod (w_lane[k])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_fund1 <= '{default: '0};
      r_coef1 <= '0;
      r_neg1  <= '0;
      r_filt1 <= 1'b0;
      r_clr1  <= 1'b0;
    end else if (w_en) begin
      r_v1    <= bus.in_valid;
      r_fund1 <= w_fund;
      r_coef1 <= bus.in_coef;
      r_neg1  <= bus.in_neg;
      r_filt1 <= bus.in_filt;
      r_clr1  <= bus.in_clear;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2    <= 1'b0;
      r_prod2 <= '{default: '0};
      r_filt2 <= 1'b0;
      r_clr2  <= 1'b0;
    end else if (w_en) begin
      r_v2    <= r_v1;
      r_prod2 <= w_lane;
      r_filt2 <= r_filt1;
      r_clr2  <= r_clr1;
    end
  end

  // transposed chain: tap k holds partial sums for lanes k+1..N-1
  always_comb begin
    for (int k = 0; k < N_LANE; k++)
      w_p[k] = ACC_W'(r_prod2[k]);
    for (int k = 0; k < NT; k++)
      w_c[k] = r_clr2 ? '0 : r_tap[k];
    w_acc_nxt = w_p[0] + w_c[0];
    for (int k = 0; k < NT - 1; k++)
      w_tap_nxt[k] = w_p[k+1] + w_c[k+1];
    w_tap_nxt[NT-1] = w_p[N_LANE-1];
    w_rnd = (ACC_W+1)'(w_acc_nxt) + (ACC_W+1)'(RND);
    w_sh  = w_rnd >>> FILT_SHIFT;
    if (w_sh < 0)
      w_filt_nxt = '0;
    else if (w_sh > MAXV)
      w_filt_nxt = '1;
    else
      w_filt_nxt = w_sh[IN_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v3    <= 1'b0;
      r_prod3 <= '0;
      r_acc3  <= '0;
      r_filt3 <= '0;
      r_tap   <= '{default: '0};
    end else if (w_en) begin
      r_v3 <= r_v2;
      if (r_v2) begin
        for (int k = 0; k < N_LANE; k++)
          r_prod3[k*OUT_W +: OUT_W] <= r_prod2[k];
        if (r_filt2) begin
          r_acc3  <= w_acc_nxt;
          r_filt3 <= w_filt_nxt;
          r_tap   <= w_tap_nxt;
        end else begin
          r_acc3  <= '0;
          r_filt3 <= '0;
          if (r_clr2) r_tap <= '{default: '0};
        end
      end
    end
  end

  assign bus.out_valid = r_v3;
  assign bus.out_prod  = r_prod3;
  assign bus.out_acc   = r_acc3;
  assign bus.out_filt  = r_filt3;
endmodule

// File: tb/tb_vvc_mcm_pipe.sv
// tb_vvc_mcm_pipe: randomized and directed checks of vvc_mcm_pipe
// against a direct-form FIR / product reference model.
module tb_vvc_mcm_pipe;
  import vvc_mcm_pkg::*;

  localparam int IN_W  = 8;
  localparam int C_W   = 6;
  localparam int N     = 4;
  localparam int OUT_W = 16;
  localparam int ACC_W = OUT_W + $clog2(N);
  localparam int FS    = 6;

  typedef struct packed {
    logic [IN_W-1:0]  x;
    logic [N*C_W-1:0] coef;
    logic [N-1:0]     neg;
    logic             filt;
    logic             clr;
  } beat_t;

  typedef struct packed {
    logic [N*OUT_W-1:0]      prod;
    logic signed [ACC_W-1:0] acc;
    logic [IN_W-1:0]         filt;
  } res_t;

  typedef struct packed {
    logic                    ir;
    logic                    ov;
    logic signed [ACC_W-1:0] acc;
  } st_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  beat_t              beat_q[$];
  res_t               exp_q[$];
  res_t               obs_q[$];
  int                 acc_cyc[$];
  int                 obs_cyc[$];
  st_t                st_q[$];
  logic [N*OUT_W-1:0] hist[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vvc_mcm_pipe_if bus ();

  vvc_mcm_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic beat_t mk(
    input int x, input int c0, input int c1,
    input int c2, input int c3,
    input logic [3:0] ng, input bit f, input bit c
  );
    beat_t b;
    b.x    = IN_W'(x);
    b.coef = {C_W'(c3), C_W'(c2), C_W'(c1), C_W'(c0)};
    b.neg  = ng;
    b.filt = f;
    b.clr  = c;
    return b;
  endfunction

  // y[n] = sum_k p_k(n-k) over filtered beats since the last clear
  function automatic res_t model(input beat_t b);
    res_t       r;
    int         p;
    longint     a;
    longint     s;
    lane_prod_t t;
    r = '0;
    for (int k = 0; k < N; k++) begin
      p = int'(b.x) * int'(b.coef[k*C_W +: C_W]);
      if (b.neg[k]) p = -p;
      r.prod[k*OUT_W +: OUT_W] = OUT_W'(p);
    end
    if (b.clr) hist.delete();
    if (b.filt) begin
      t = r.prod[0 +: OUT_W];
      a = t;
      for (int d = 1; d < N; d++) begin
        if (hist.size() >= d) begin
          t = hist[hist.size()-d][d*OUT_W +: OUT_W];
          a += t;
        end
      end
      hist.push_back(r.prod);
      while (hist.size() > N - 1) void'(hist.pop_front());
      s = (a + (1 << (FS - 1))) >>> FS;
      r.acc  = ACC_W'(a);
      r.filt = (s < 0) ? 8'd0 : (s > 255) ? 8'd255 : IN_W'(s);
    end
    return r;
  endfunction

  task automatic flush();
    exp_q.delete();
    obs_q.delete();
    acc_cyc.delete();
    obs_cyc.delete();
    st_q.delete();
  endtask

  task automatic drive(input bit gaps);
    int w;
    bit ok;
    for (int i = 0; i < beat_q.size(); i++) begin
      w = 0;
      ok = 0;
      @(negedge clk);
      if (gaps) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      bus.in_x     = beat_q[i].x;
      bus.in_coef  = beat_q[i].coef;
      bus.in_neg   = beat_q[i].neg;
      bus.in_filt  = beat_q[i].filt;
      bus.in_clear = beat_q[i].clr;
      bus.in_valid = 1'b1;
      while (!ok && w < 100) begin
        #4;
        if (bus.in_ready) begin
          acc_cyc.push_back(cyc);
          exp_q.push_back(model(beat_q[i]));
          ok = 1;
          @(posedge clk);
        end else begin
          @(negedge clk);
          w++;
        end
      end
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL drive_timeout beat %0d in_ready stuck 0, need 1", i);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    beat_q.delete();
  endtask

  task automatic collect(input int n, input int st_len, input bit rnd);
    int got, lim, stall;
    bit seen, stl;
    got = 0;
    lim = 0;
    stall = 0;
    seen = 0;
    while (got < n && lim < n * 10 + 50) begin
      @(negedge clk);
      lim++;
      stl = 0;
      if (bus.out_valid) seen = 1;
      if (seen && stall < st_len) begin
        bus.out_ready = 1'b0;
        stall++;
        stl = 1;
      end else if (rnd) begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        bus.out_ready = 1'b1;
      end
      #3;
      if (stl)
        st_q.push_back('{bus.in_ready, bus.out_valid, bus.out_acc});
      if (bus.out_valid && bus.out_ready) begin
        obs_q.push_back('{bus.out_prod, bus.out_acc, bus.out_filt});
        obs_cyc.push_back(cyc);
        got++;
      end
    end
    if (got < n) begin
      checks++;
      errors++;
      $display("FAIL collect_timeout got %0d beats, need %0d", got, n);
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_coef   = '0;
    bus.in_neg    = '0;
    bus.in_filt   = 1'b0;
    bus.in_clear  = 1'b0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_out_valid got %b need 0", bus.out_valid);
    end
    checks++;
    if (bus.out_prod !== '0 || bus.out_acc !== '0) begin
      errors++;
      $display("FAIL rst_data prod %h acc %h need 0", bus.out_prod, bus.out_acc);
    end
    checks++;
    if (bus.out_filt !== '0) begin
      errors++;
      $display("FAIL rst_filt got %h need 0", bus.out_filt);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle in_ready %b out_valid %b need 1 0",
               bus.in_ready, bus.out_valid);
    end
    hist.delete();
    flush();
  endtask

  task automatic test_products();
    int         ep [4];
    lane_prod_t t;
    ep = '{0, 200, 6400, 12600};
    flush();
    beat_q.push_back(mk(200, 0, 1, 32, 63, 4'b0000, 0, 0));
    for (int i = 0; i < 16; i++)
      beat_q.push_back(mk($urandom_range(0, 255),
        $urandom_range(0, 63), $urandom_range(0, 63),
        $urandom_range(0, 63), $urandom_range(0, 63),
        4'($urandom_range(0, 15)), 0, 0));
    fork
      drive(0);
      collect(17, 0, 0);
    join
    if (obs_q.size() > 0) begin
      for (int k = 0; k < N; k++) begin
        t = obs_q[0].prod[k*OUT_W +: OUT_W];
        checks++;
        if (t !== lane_prod_t'(ep[k])) begin
          errors++;
          $display("FAIL prod_fixed lane %0d got %0d need %0d", k, t, ep[k]);
        end
      end
      checks++;
      if (obs_q[0].acc !== '0 || obs_q[0].filt !== '0) begin
        errors++;
        $display("FAIL prod_nofilt acc %0d filt %0d need 0 0",
                 obs_q[0].acc, obs_q[0].filt);
      end
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL prod_rand %0d got %h need %h", i, obs_q[i], exp_q[i]);
      end
      checks++;
      if (obs_cyc[i] - acc_cyc[i] !== 3) begin
        errors++;
        $display("FAIL latency %0d got %0d need 3", i, obs_cyc[i] - acc_cyc[i]);
      end
    end
  endtask

  task automatic test_neg();
    int         ep [4];
    lane_prod_t t;
    ep = '{-16065, -510, 0, 1275};
    flush();
    beat_q.push_back(mk(255, 63, 2, 0, 5, 4'b0011, 0, 0));
    fork
      drive(0);
      collect(1, 0, 0);
    join
    for (int k = 0; k < N && obs_q.size() > 0; k++) begin
      t = obs_q[0].prod[k*OUT_W +: OUT_W];
      checks++;
      if (t !== lane_prod_t'(ep[k])) begin
        errors++;
        $display("FAIL prod_neg lane %0d got %0d need %0d", k, t, ep[k]);
      end
    end
  endtask

  task automatic push_fir(input int clr_at);
    int xs [4];
    xs = '{10, 20, 30, 40};
    for (int i = 0; i < 4; i++)
      beat_q.push_back(mk(xs[i], 4, 36, 36, 4, 4'b1001, 1,
                          (i == 0) || (i == clr_at)));
  endtask

  task automatic test_fir();
    int ea [4];
    int ef [4];
    logic signed [ACC_W-1:0] a;
    ea = '{-40, 280, 960, 1600};
    ef = '{0, 4, 15, 25};
    flush();
    push_fir(-1);
    fork
      drive(0);
      collect(4, 0, 0);
    join
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      a = obs_q[i].acc;
      checks++;
      if (a !== ACC_W'(ea[i]) || obs_q[i].filt !== IN_W'(ef[i])) begin
        errors++;
        $display("FAIL fir %0d acc %0d filt %0d need %0d %0d",
                 i, a, obs_q[i].filt, ea[i], ef[i]);
      end
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL fir_model %0d got %h need %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int ea [4];
    logic signed [ACC_W-1:0] a;
    ea = '{-40, 280, 960, 1600};
    flush();
    push_fir(-1);
    fork
      drive(0);
      collect(4, 5, 0);
    join
    checks++;
    if (st_q.size() !== 5) begin
      errors++;
      $display("FAIL bp_stall_len got %0d need 5", st_q.size());
    end
    for (int i = 0; i < st_q.size(); i++) begin
      checks++;
      if (st_q[i].ir !== 1'b0 || st_q[i].ov !== 1'b1 || st_q[i].acc !== -40) begin
        errors++;
        $display("FAIL bp_hold %0d ir %b ov %b acc %0d need 0 1 -40",
                 i, st_q[i].ir, st_q[i].ov, st_q[i].acc);
      end
    end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      a = obs_q[i].acc;
      checks++;
      if (a !== ACC_W'(ea[i])) begin
        errors++;
        $display("FAIL bp_acc %0d got %0d need %0d", i, a, ea[i]);
      end
    end
  endtask

  task automatic test_clear_mid();
    int ea [4];
    int ef [4];
    logic signed [ACC_W-1:0] a;
    ea = '{-40, 280, -120, 920};
    ef = '{0, 4, 0, 14};
    flush();
    push_fir(2);
    fork
      drive(0);
      collect(4, 0, 0);
    join
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      a = obs_q[i].acc;
      checks++;
      if (a !== ACC_W'(ea[i]) || obs_q[i].filt !== IN_W'(ef[i])) begin
        errors++;
        $display("FAIL clear_mid %0d acc %0d filt %0d need %0d %0d",
                 i, a, obs_q[i].filt, ea[i], ef[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic signed [ACC_W-1:0] a;
    flush();
    beat_q.push_back(mk(50, 4, 36, 36, 4, 4'b1001, 1, 1));
    fork
      drive(0);
      collect(1, 0, 0);
    join
    flush();
    beat_q.push_back(mk(60, 4, 36, 36, 4, 4'b1001, 1, 0));
    beat_q.push_back(mk(70, 4, 36, 36, 4, 4'b1001, 1, 0));
    drive(0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    hist.delete();
    flush();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_drop cycle %0d out_valid %b need 0", i, bus.out_valid);
      end
    end
    beat_q.push_back(mk(10, 4, 36, 36, 4, 4'b1001, 1, 0));
    fork
      drive(0);
      collect(1, 0, 0);
    join
    if (obs_q.size() > 0) begin
      a = obs_q[0].acc;
      checks++;
      if (a !== -40) begin
        errors++;
        $display("FAIL rst_mid_chain acc %0d need -40", a);
      end
    end
  endtask

  task automatic test_random();
    int n;
    n = 300;
    flush();
    for (int i = 0; i < n; i++)
      beat_q.push_back(mk($urandom_range(0, 255),
        $urandom_range(0, 63), $urandom_range(0, 63),
        $urandom_range(0, 63), $urandom_range(0, 63),
        4'($urandom_range(0, 15)),
        $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0));
    fork
      drive(1);
      collect(n, 0, 1);
    join
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL rand_count got %0d need %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rand %0d got %h need %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_products();
    test_neg();
    test_fir();
    test_backpressure();
    test_clear_mid();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
